// File: rtl/issue_scheduler.sv
// issue_scheduler: picks the oldest ready reservation-buffer entry for each of the
// ALU, BRANCH and MEM ports. It pulses a mark so the buffer can retire the entry to
// S_EXECUTING, and holds a registered copy until the execution unit accepts it.
// MEM issues strictly in program order. A mispredict flush drops held issues on the
// killed speculative path.
// Optional feature: define ISSUE_STALL_CNT_EN to build saturating per-port stall counters.

package issue_scheduler_pkg;
  localparam int unsigned BUF_SIZE  = 8;
  localparam int unsigned IDX_W     = $clog2(BUF_SIZE);
  localparam int unsigned SPECTAG_W = 6;

  typedef logic [IDX_W-1:0]     index_t;
  typedef logic [SPECTAG_W-1:0] spectag_t;

  typedef enum logic [1:0] {S_EMPTY, S_NOT_EXECUTED, S_EXECUTING, S_DONE} e_state_t;
  typedef enum logic [1:0] {UNIT_ALU, UNIT_BRANCH, UNIT_LOAD, UNIT_STORE} unit_t;

  typedef struct packed {
    e_state_t    e_state;
    unit_t       unit;
    logic        j_rdy;
    logic        k_rdy;
    spectag_t    speculative_tag;
    logic [15:0] op;
  } entry_t;
endpackage

module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int unsigned BUF_SIZE = issue_scheduler_pkg::BUF_SIZE,
  parameter int unsigned NPORT    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  entry_t            entries_all [BUF_SIZE],
  input  logic              flush_valid,
  input  spectag_t          flush_tag,
  output logic [NPORT-1:0]  issue_valid,
  input  logic [NPORT-1:0]  issue_ready,
  output entry_t            issue_entry [NPORT],
  output index_t            issue_index [NPORT],
  output logic [NPORT-1:0]  mark_valid,
  output index_t            mark_index  [NPORT],
  output logic [31:0]       stall_cnt   [NPORT]
);

  localparam int unsigned PortAlu    = 0;
  localparam int unsigned PortBranch = 1;
  localparam int unsigned PortMem    = 2;

  logic [NPORT-1:0] cand_ok;
  index_t           cand_idx [NPORT];
  logic [NPORT-1:0] capture;
  logic [NPORT-1:0] kill;
  logic             mem_seen;

  // Oldest eligible entry per port; MEM stops at the oldest memory op whether or not it is ready.
  always_comb begin
    cand_ok  = '0;
    mem_seen = 1'b0;
    for (int p = 0; p < NPORT; p++) cand_idx[p] = '0;
    for (int i = 0; i < BUF_SIZE; i++) begin
      if (entries_all[i].e_state == S_NOT_EXECUTED) begin
        if (entries_all[i].unit == UNIT_LOAD || entries_all[i].unit == UNIT_STORE) begin
          if (!mem_seen) begin
            mem_seen = 1'b1;
            if (entries_all[i].j_rdy && entries_all[i].k_rdy) begin
              cand_ok[PortMem]  = 1'b1;
              cand_idx[PortMem] = index_t'(i);
            end
          end
        end else if (entries_all[i].unit == UNIT_ALU) begin
          if (!cand_ok[PortAlu] && entries_all[i].j_rdy && entries_all[i].k_rdy) begin
            cand_ok[PortAlu]  = 1'b1;
            cand_idx[PortAlu] = index_t'(i);
          end
        end else begin
          if (!cand_ok[PortBranch] && entries_all[i].j_rdy && entries_all[i].k_rdy) begin
            cand_ok[PortBranch]  = 1'b1;
            cand_idx[PortBranch] = index_t'(i);
          end
        end
      end
    end
  end

  // Capture decision and mark pulse; gated by rst_n so marks read zero while in reset.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      capture[p]    = rst_n && cand_ok[p] && !flush_valid && (!issue_valid[p] || issue_ready[p]);
      kill[p]       = flush_valid && (|(issue_entry[p].speculative_tag & flush_tag));
      mark_index[p] = cand_idx[p];
    end
    mark_valid = capture;
  end

  // Held issue slot per port: capture has priority, flush kill or accept releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid <= '0;
      for (int p = 0; p < NPORT; p++) begin
        issue_entry[p] <= '0;
        issue_index[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        if (capture[p]) begin
          issue_valid[p] <= 1'b1;
          issue_entry[p] <= entries_all[cand_idx[p]];
          issue_index[p] <= cand_idx[p];
        end else if (issue_valid[p] && (kill[p] || issue_ready[p])) begin
          issue_valid[p] <= 1'b0;
        end
      end
    end
  end

`ifdef ISSUE_STALL_CNT_EN
  // Saturating count of cycles a held issue waits on its unit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NPORT; p++) stall_cnt[p] <= '0;
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        if (issue_valid[p] && !issue_ready[p] && (stall_cnt[p] != 32'hFFFF_FFFF)) begin
          stall_cnt[p] <= stall_cnt[p] + 32'd1;
        end
      end
    end
  end
`else
  // Counters not built: outputs tied low.
  always_comb begin
    for (int p = 0; p < NPORT; p++) stall_cnt[p] = '0;
  end
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: scoreboard bench for issue_scheduler. A behavioural buffer and
// per-port model predict marks; predicted issues are queued at capture and compared
// when the port releases them.

module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  localparam int unsigned NP = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  entry_t          bufm [BUF_SIZE];
  logic            flush_valid;
  spectag_t        flush_tag;
  logic [NP-1:0]   issue_valid;
  logic [NP-1:0]   issue_ready;
  entry_t          issue_entry [NP];
  index_t          issue_index [NP];
  logic [NP-1:0]   mark_valid;
  index_t          mark_index [NP];
  logic [31:0]     stall_cnt [NP];

  always #5 clk = ~clk;

  issue_scheduler #(.BUF_SIZE(BUF_SIZE), .NPORT(NP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .entries_all (bufm),
    .flush_valid (flush_valid),
    .flush_tag   (flush_tag),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_entry (issue_entry),
    .issue_index (issue_index),
    .mark_valid  (mark_valid),
    .mark_index  (mark_index),
    .stall_cnt   (stall_cnt)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  int q_alu[$];
  int q_br[$];
  int q_mem[$];

  bit              mv [NP];
  entry_t          me [NP];
  longint unsigned ms [NP];
  bit              m_ok [NP];
  int              m_idx [NP];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int p, input int idx);
    case (p)
      0:       q_alu.push_back(idx);
      1:       q_br.push_back(idx);
      default: q_mem.push_back(idx);
    endcase
  endtask

  function automatic int peek_exp(input int p);
    case (p)
      0:       return (q_alu.size() > 0) ? q_alu[0] : -1;
      1:       return (q_br.size() > 0) ? q_br[0] : -1;
      default: return (q_mem.size() > 0) ? q_mem[0] : -1;
    endcase
  endfunction

  task automatic drop_exp(input int p);
    case (p)
      0:       if (q_alu.size() > 0) void'(q_alu.pop_front());
      1:       if (q_br.size() > 0) void'(q_br.pop_front());
      default: if (q_mem.size() > 0) void'(q_mem.pop_front());
    endcase
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      mv[p] = 1'b0;
      me[p] = '0;
      ms[p] = 0;
    end
    q_alu.delete();
    q_br.delete();
    q_mem.delete();
  endtask

  function automatic entry_t mk(input unit_t u, input bit j, input bit k, input spectag_t t,
                                input logic [15:0] op);
    entry_t e;
    e.e_state         = S_NOT_EXECUTED;
    e.unit            = u;
    e.j_rdy           = j;
    e.k_rdy           = k;
    e.speculative_tag = t;
    e.op              = op;
    return e;
  endfunction

  task automatic clear_buf();
    for (int i = 0; i < BUF_SIZE; i++) bufm[i] = '0;
  endtask

  // Reference selection: oldest ready ALU/BRANCH; MEM only if the oldest memory op is ready.
  task automatic model_select();
    bit mem_done;
    int p;
    mem_done = 1'b0;
    for (int q = 0; q < NP; q++) begin
      m_ok[q]  = 1'b0;
      m_idx[q] = 0;
    end
    for (int i = 0; i < BUF_SIZE; i++) begin
      if (bufm[i].e_state != S_NOT_EXECUTED) continue;
      if (bufm[i].unit inside {UNIT_LOAD, UNIT_STORE}) begin
        if (!mem_done) begin
          mem_done = 1'b1;
          if (bufm[i].j_rdy && bufm[i].k_rdy) begin
            m_ok[2]  = 1'b1;
            m_idx[2] = i;
          end
        end
      end else begin
        p = (bufm[i].unit == UNIT_ALU) ? 0 : 1;
        if (!m_ok[p] && bufm[i].j_rdy && bufm[i].k_rdy) begin
          m_ok[p]  = 1'b1;
          m_idx[p] = i;
        end
      end
    end
  endtask

  // One clock: compare before the edge, advance model, apply buffer marks after the edge.
  task automatic tick();
    bit cap [NP];
    bit kill;
    #2;
    model_select();
    for (int p = 0; p < NP; p++) begin
      cap[p] = m_ok[p] && !flush_valid && (!mv[p] || issue_ready[p]);
      check_eq($sformatf("mark_valid[%0d]", p), mark_valid[p], cap[p]);
      if (cap[p]) check_eq($sformatf("mark_index[%0d]", p), mark_index[p], m_idx[p]);
      check_eq($sformatf("issue_valid[%0d]", p), issue_valid[p], mv[p]);
      check_eq($sformatf("stall_cnt[%0d]", p), stall_cnt[p], ms[p]);
      kill = mv[p] && flush_valid && (|(me[p].speculative_tag & flush_tag));
`ifdef ISSUE_STALL_CNT_EN
      if (mv[p] && !issue_ready[p] && ms[p] != 64'hFFFF_FFFF) ms[p]++;
`endif
      if (mv[p]) begin
        check_eq($sformatf("issue_index[%0d]", p), issue_index[p], peek_exp(p));
        check_eq($sformatf("issue_entry[%0d]", p), issue_entry[p], me[p]);
        if (kill || issue_ready[p]) begin
          drop_exp(p);
          mv[p] = 1'b0;
        end
      end
      if (cap[p]) begin
        push_exp(p, m_idx[p]);
        mv[p] = 1'b1;
        me[p] = bufm[m_idx[p]];
      end
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) if (cap[p]) bufm[m_idx[p]].e_state = S_EXECUTING;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " issue_valid"}, issue_valid, '0);
    check_eq({tag, " mark_valid"}, mark_valid, '0);
    for (int p = 0; p < NP; p++) begin
      check_eq($sformatf("%s issue_index[%0d]", tag, p), issue_index[p], '0);
      check_eq($sformatf("%s issue_entry[%0d]", tag, p), issue_entry[p], '0);
      check_eq($sformatf("%s stall_cnt[%0d]", tag, p), stall_cnt[p], '0);
    end
  endtask

  task automatic drain();
    issue_ready = '1;
    flush_valid = 1'b0;
    repeat (3) tick();
  endtask

  function automatic entry_t rand_entry();
    spectag_t t;
    t = ($urandom_range(0, 2) == 0) ? spectag_t'(0) : spectag_t'(6'b1 << $urandom_range(0, 5));
    return mk(unit_t'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              t, 16'($urandom));
  endfunction

  initial begin
    rst_n       = 1'b0;
    flush_valid = 1'b0;
    flush_tag   = '0;
    issue_ready = '0;
    clear_buf();
    model_reset();
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Two ready ALU ops: back-to-back issue in age order.
    clear_buf();
    issue_ready = '1;
    bufm[2] = mk(UNIT_ALU, 1, 1, 6'b0, 16'h0102);
    bufm[5] = mk(UNIT_ALU, 1, 1, 6'b0, 16'h0105);
    repeat (3) tick();

    // Oldest MEM op not ready blocks a younger ready load.
    clear_buf();
    bufm[1] = mk(UNIT_STORE, 1, 0, 6'b0, 16'h0201);
    bufm[3] = mk(UNIT_LOAD, 1, 1, 6'b0, 16'h0203);
    repeat (2) tick();
    bufm[1].k_rdy = 1'b1;
    repeat (3) tick();

    // Held BRANCH stalls for four cycles; next branch waits for ready.
    clear_buf();
    issue_ready = 3'b101;
    bufm[0] = mk(UNIT_BRANCH, 1, 1, 6'b0, 16'h0300);
    tick();
    bufm[4] = mk(UNIT_BRANCH, 1, 1, 6'b0, 16'h0304);
    repeat (4) tick();
    issue_ready = '1;
    repeat (3) tick();

    // Flush kills the ALU issue on the tagged path, keeps MEM, blocks marks.
    clear_buf();
    issue_ready = '0;
    bufm[0] = mk(UNIT_ALU, 1, 1, 6'b000011, 16'h0400);
    bufm[1] = mk(UNIT_LOAD, 1, 1, 6'b000001, 16'h0401);
    bufm[2] = mk(UNIT_ALU, 1, 1, 6'b000000, 16'h0402);
    tick();
    flush_valid = 1'b1;
    flush_tag   = 6'b000010;
    tick();
    flush_valid = 1'b0;
    issue_ready = '1;
    repeat (3) tick();

    // Reset mid-issue with all ports held and an eligible entry pending.
    clear_buf();
    issue_ready = '0;
    bufm[0] = mk(UNIT_ALU, 1, 1, 6'b0, 16'h0500);
    bufm[1] = mk(UNIT_BRANCH, 1, 1, 6'b0, 16'h0501);
    bufm[2] = mk(UNIT_STORE, 1, 1, 6'b0, 16'h0502);
    bufm[3] = mk(UNIT_ALU, 1, 1, 6'b0, 16'h0503);
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    issue_ready = '1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();

    // Random traffic with occasional flushes.
    clear_buf();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < BUF_SIZE; i++) begin
        if (bufm[i].e_state != S_NOT_EXECUTED) begin
          if ($urandom_range(0, 3) == 0) bufm[i] = rand_entry();
        end else if ($urandom_range(0, 2) == 0) begin
          bufm[i].j_rdy = 1'b1;
          bufm[i].k_rdy = 1'b1;
        end
      end
      issue_ready = NP'($urandom);
      flush_valid = ($urandom_range(0, 9) == 0);
      flush_tag   = spectag_t'(6'b1 << $urandom_range(0, 5));
      tick();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Selects ready instructions from the reservation buffer and issues them to three execution ports: ALU, BRANCH and MEM. Each port has a registered valid/ready handshake. The block sits between the buffer and the execution units. In the cycle it captures an entry, it pulses a mark so the buffer moves that entry from S_NOT_EXECUTED to S_EXECUTING. The MEM port issues strictly in program order. Branch-mispredict flushes drop held issues that are on the killed speculative path.

## Interface
Parameters:
- BUF_SIZE, package value: number of buffer entries. Lower index means older.
- NPORT, 3, fixed: port 0 = ALU, port 1 = BRANCH, port 2 = MEM.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- entries_all  in  entry_t[BUF_SIZE]  buffer snapshot.
- flush_valid  in  1  mispredict flush this cycle.
- flush_tag  in  spectag_t  one-hot speculative tag being killed.
- issue_valid  out  1[NPORT]  port holds an instruction.
- issue_ready  in  1[NPORT]  unit accepts this cycle.
- issue_entry  out  entry_t[NPORT]  held entry copy.
- issue_index  out  index_t[NPORT]  buffer index of held entry.
- mark_valid  out  1[NPORT]  combinational pulse: capture happens at this edge.
- mark_index  out  index_t[NPORT]  entry to set to S_EXECUTING.
- stall_cnt  out  32[NPORT]  stall counters (see Configuration).

## Operation
Eligibility, per port p:
- ALU and BRANCH: entry e_state==S_NOT_EXECUTED, J_rdy, K_rdy, and Unit matching p.
- The candidate is the lowest eligible index.

MEM ordering:
- Find the lowest index with e_state==S_NOT_EXECUTED and Unit in {LOAD, STORE}.
- It is the candidate only if J_rdy && K_rdy. Otherwise MEM issues nothing; it never bypasses the oldest MEM entry.

Capture:
- Condition: candidate exists, flush_valid==0, and (!issue_valid[p] || issue_ready[p]).
- mark_valid[p]=1 and mark_index[p]=candidate in that cycle.
- On the clock edge: issue_entry/issue_index load and issue_valid[p]=1.

Release:
- When issue_valid && issue_ready with no capture in the same cycle, issue_valid clears.
- Accept plus capture in the same cycle gives back-to-back issue, one instruction per port per cycle.

Flush (flush_valid==1):
- No captures on any port; all mark_valid=0.
- A held entry with (issue_entry.speculative_tag & flush_tag)!=0 has issue_valid cleared at the edge, even if issue_ready was high.
- Held entries outside the flushed path are unaffected and keep handshaking normally.

Marks:
- The buffer must update e_state at the same edge. The scheduler keeps no pending mask.
- At most one mark per port per cycle. The three ports always select distinct entries because their Unit classes are disjoint.

## Timing
- Reset values: issue_valid=0, issue_entry='0, issue_index=0, stall_cnt=0, mark_valid=0.
- An entry that becomes eligible in cycle N is captured at the end of cycle N and is valid at issue_* in cycle N+1.
- Selection-to-mark path is combinational. Payload output is registered.
- Handshake: once issue_valid is set, issue_entry and issue_index stay stable until accepted or flushed.
- Reset mid-operation: all held issues are discarded immediately.
- Empty buffer or no eligible entry: mark_valid=0 and the port holds its state.
- Full buffer: no special behaviour.

## Configuration
ISSUE_STALL_CNT_EN:
- Defined: stall_cnt[p] increments by 1 each cycle with issue_valid[p] && !issue_ready[p].
  - Saturates at 32'hFFFF_FFFF.
  - Clears only on reset.
- Undefined: stall_cnt is tied to 0 and no counter flops exist.

## Test plan
- ALU entries at indexes 2 and 5, both ready, issue_ready=1 -> mark index 2 in cycle 0, index 5 in cycle 1; issue_valid stays high both cycles.
- MEM: STORE at idx1 with K_rdy=0, LOAD at idx3 ready -> no MEM mark; after idx1 K_rdy=1 -> idx1 issues first, idx3 on the next capture.
- Held BRANCH with issue_ready=0 for 4 cycles (macro defined) -> entry stable, stall_cnt[1]=4, no BRANCH mark until ready rises.
- flush_valid=1, flush_tag=6'b000010; held ALU entry spectag 6'b000011, held MEM entry spectag 6'b000001 -> ALU valid drops, MEM kept, no marks that cycle.
- rst_n asserted low mid-issue with all ports valid -> all outputs zero asynchronously; first capture possible in the first cycle after release.
